// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch controller.
package fetch_ctrl_pkg;

   typedef logic [63:0] u64;
   typedef logic [31:0] u32;

   typedef enum logic [1:0] {BOOT, REQ, DISCARD, HOLD} fetch_state_t;

   localparam u64 PC_RESET = 64'h0000_0000_8000_0000;

   function automatic logic is_misaligned(input u64 pc);
      return pc[1:0] != 2'b00;
   endfunction

endpackage

// File: rtl/pcselect.sv
// Next-PC mux: sequential pc+4 or the execute-stage redirect target.
module pcselect
   import fetch_ctrl_pkg::*;
(
   input  u64   pcplus4,
   input  u64   pc_branch,
   input  logic branch_taken,
   output u64   pc_next
);

   assign pc_next = branch_taken ? pc_branch : pcplus4;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction fetch sequencer: owns the fetch PC, runs the instruction-bus
// handshake, applies execute redirects and presents one instruction to decode.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter u64 RESET_PC = PC_RESET
)
(
   input  logic clk,
   input  logic reset,
   output logic ireq_valid,
   output u64   ireq_addr,
   input  logic iresp_data_ok,
   input  u32   iresp_data,
   input  logic branch_taken,
   input  u64   pc_branch,
   input  logic stall,
   output logic out_valid,
   output u64   out_pc,
   output u32   out_instr,
   output logic out_misaligned
);

   fetch_state_t r_state, w_state_nxt;
   u64   r_pc, w_pc_nxt;
   u64   r_redirect_pc, w_redirect_nxt;
   logic r_ovalid, w_ovalid_nxt;
   u64   r_opc, w_opc_nxt;
   u32   r_oinstr, w_oinstr_nxt;
   logic r_omis, w_omis_nxt;
   u64   w_pcplus4, w_pcsel;
   logic w_mis, w_br_gated;

   assign w_pcplus4  = r_pc + 64'd4;
   assign w_mis      = is_misaligned(r_pc);
   assign w_br_gated = branch_taken && (r_state != BOOT);

   pcselect u_pcselect (
      .pcplus4      (w_pcplus4),
      .pc_branch    (pc_branch),
      .branch_taken (w_br_gated),
      .pc_next      (w_pcsel)
   );

   always_comb begin
      w_state_nxt    = r_state;
      w_pc_nxt       = r_pc;
      w_redirect_nxt = r_redirect_pc;
      w_ovalid_nxt   = r_ovalid;
      w_opc_nxt      = r_opc;
      w_oinstr_nxt   = r_oinstr;
      w_omis_nxt     = r_omis;
      case (r_state)
         BOOT: w_state_nxt = REQ;
         REQ: begin
            if (w_mis) begin
               w_opc_nxt    = r_pc;
               w_oinstr_nxt = '0;
               w_omis_nxt   = 1'b1;
               w_ovalid_nxt = 1'b1;
               w_state_nxt  = HOLD;
            end else if (iresp_data_ok) begin
               // pcselect yields pc_branch when redirected, else pc+4
               w_pc_nxt = w_pcsel;
               if (!branch_taken) begin
                  w_opc_nxt    = r_pc;
                  w_oinstr_nxt = iresp_data;
                  w_omis_nxt   = 1'b0;
                  w_ovalid_nxt = 1'b1;
                  w_state_nxt  = HOLD;
               end
            end else if (branch_taken) begin
               w_redirect_nxt = pc_branch;
               w_state_nxt    = DISCARD;
            end
         end
         DISCARD: begin
            if (branch_taken)
               w_redirect_nxt = pc_branch;
            if (iresp_data_ok) begin
               w_pc_nxt    = branch_taken ? w_pcsel : r_redirect_pc;
               w_state_nxt = REQ;
            end
         end
         HOLD: begin
            // A misaligned fault only leaves HOLD via a redirect
            if (branch_taken) begin
               w_ovalid_nxt = 1'b0;
               w_pc_nxt     = w_pcsel;
               w_state_nxt  = REQ;
            end else if (!stall && !r_omis) begin
               w_ovalid_nxt = 1'b0;
               w_state_nxt  = REQ;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state       <= BOOT;
         r_pc          <= RESET_PC;
         r_redirect_pc <= '0;
         r_ovalid      <= 1'b0;
         r_opc         <= '0;
         r_oinstr      <= '0;
         r_omis        <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_pc          <= w_pc_nxt;
         r_redirect_pc <= w_redirect_nxt;
         r_ovalid      <= w_ovalid_nxt;
         r_opc         <= w_opc_nxt;
         r_oinstr      <= w_oinstr_nxt;
         r_omis        <= w_omis_nxt;
      end
   end

   assign ireq_valid     = ((r_state == REQ) && !w_mis) || (r_state == DISCARD);
   assign ireq_addr      = r_pc;
   assign out_valid      = r_ovalid;
   assign out_pc         = r_opc;
   assign out_instr      = r_oinstr;
   assign out_misaligned = r_omis;

endmodule
